decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
// - ID stage of the 5-stage core, directly downstream of the fetch stage; consumes InstrD/PCD/PCPlus4D.
// - Splits the 33-bit instruction, reads the 16x32 register file and generates control.
// - Registers everything into the ID/EX pipeline register for the execute stage.
// - Owns the register file; WB writes it via RegWriteW/RDW/ResultW.
// PARAMETERS
// - DATA_W  32  register/operand width
// - PC_W    9   instruction address width (matches fetch)
// - NREG    16  architectural registers; R0 reads 0, R15 is link register
// PORTS
// - clk        in   1       clock
// - rst        in   1       reset, asynchronous, active-low
// - InstrD     in   33      instr: [32:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16
// - PCD        in   PC_W    PC of InstrD
// - PCPlus4D   in   PC_W    PCD+1 (word-addressed)
// - StallD     in   1       hold ID/EX register contents
// - FlushE     in   1       replace ID/EX contents with bubble
// - RegWriteW  in   1       WB write enable
// - RDW        in   4       WB destination register
// - ResultW    in   DATA_W  WB write data
// - RD1E,RD2E  out  DATA_W  operands (rs1, rs2)
// - ImmExtE    out  DATA_W  sign-extended imm16
// - RdE,Rs1E,Rs2E out 4     register indices for hazard unit
// - PCE,PCPlus4E out PC_W   pipelined PC values
// - ALUControlE out 4       ALU op code
// - ALUSrcE, RegWriteE, MemWriteE, ResultSrcE (2b), BranchE, BranchNeE, JumpE, CallE, ReturnE out  control
// - IllegalE   out  1       undefined opcode seen
// BEHAVIOUR
// - Decode is combinational from InstrD; every output is registered; latency 1 clk.
// - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 ADDI, 9 LDR, 10 STR, 11 BEQ, 12 BNE, 13 JMP, 14 CALL, 15 RET.
// - Opcodes 16-31: all control 0 (NOP bubble), IllegalE=1.
// - ADDI/LDR/STR: ALUSrcE=1, ALU=ADD. LDR: ResultSrcE=01. STR: MemWriteE=1, RegWriteE=0.
// - CALL: JumpE=CallE=1, RegWriteE=1, RdE forced to 15, ResultSrcE=10 (PCPlus4).
// - RET: ReturnE=1; RD1E carries R15. Execute drives PCReturnE = RD1E[PC_W-1:0].
// - BEQ/BNE: BranchE / BranchNeE=1, ALU=SUB, RegWriteE=0.
// - Register file: write on posedge clk when RegWriteW && RDW!=0.
// - R0 write ignored; reads of R0 return 0.
// - Priority FlushE > StallD > load.
// - FlushE: every control bit and IllegalE cleared; data fields are don't-care (cleared).
// - StallD: all ID/EX outputs hold their values.
// - Reset (rst=0, async): every output 0; all registers cleared to 0.
// - Reset mid-operation discards the in-flight instruction.
// - First decode after reset release sees InstrD from fetch's pre-fetch.
// CONFIGURATION
// - DECODE_BYPASS_EN defined:
//   - Same-cycle WB write to a register that is also read returns ResultW (write-through).
//   - Applies to rs1, rs2 and the implicit R15 read; never to R0.
// - DECODE_BYPASS_EN undefined:
//   - Read returns the old register value.
//   - The hazard unit stalls one extra cycle.
// STRUCTURE
// - Package decode_pkg: opcode_e enum, alu_ctrl_e enum, result_src_e, field bit positions, LINK_REG=15.
// - Sub-module register_file (NREG x DATA_W, 3 async read ports, 1 sync write port, bypass under macro).
// - decode_cycle holds the control decoder and the ID/EX register.
// TESTING
// - Reset release: all outputs 0.
//   Then ADDI r1,r0,#-3 -> next clk ImmExtE=32'hFFFFFFFD, ALUSrcE=1, RegWriteE=1, RdE=1.
// - WB write R5=0x1234 and, same cycle, decode ADD r2,r5,r5:
//   - with macro: RD1E=RD2E=0x1234.
//   - without macro: old value (0).
// - CALL at PCD=0x040 -> JumpE=CallE=1, RdE=15, PCPlus4E=0x041.
//   Then WB R15=0x041 and RET -> ReturnE=1, RD1E[8:0]=0x041.
// - StallD high 3 cycles during STR -> outputs constant, MemWriteE=1 held.
//   FlushE and StallD both high -> all control 0.
// - Opcode 5'd20 -> IllegalE=1, RegWriteE=MemWriteE=0.
//   WB write to R0 with 0xFFFF -> R0 still reads 0.
// - rst pulled low mid-stream -> outputs 0 immediately, regfile cleared.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types, widths and instruction field positions for the ID stage.
package decode_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_W    = 9;
  localparam int unsigned NREG    = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned INSTR_W = 33;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(15);

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_ADDI = 5'd8,
    OP_LDR  = 5'd9,
    OP_STR  = 5'd10,
    OP_BEQ  = 5'd11,
    OP_BNE  = 5'd12,
    OP_JMP  = 5'd13,
    OP_CALL = 5'd14,
    OP_RET  = 5'd15
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    alu_ctrl_e   alu;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        call;
    logic        ret;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
    ctrl_t             ctrl;
  } idex_t;

endpackage

// File: rtl/register_file.sv
// 16x32 register file: three async read ports, one sync write port, R0 hardwired to zero.
// Write-through from the WB port to the read ports is enabled by DECODE_BYPASS_EN.
module register_file
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] ra3,
  output logic [DATA_W-1:0] rd1_c,
  output logic [DATA_W-1:0] rd2_c,
  output logic [DATA_W-1:0] rd3_c
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

`ifdef DECODE_BYPASS_EN
  // Same-cycle WB data wins over the stored value, except for R0.
  assign rd1_c = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2_c = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);
  assign rd3_c = (ra3 == '0) ? '0 : ((we && (wa == ra3)) ? wd : regs[ra3]);
`else
  assign rd1_c = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2_c = (ra2 == '0) ? '0 : regs[ra2];
  assign rd3_c = (ra3 == '0) ? '0 : regs[ra3];
`endif

endmodule

// File: rtl/decode_cycle.sv
// ID stage: splits the instruction, reads the register file, decodes control and
// registers everything into ID/EX. Optional WB write-through: DECODE_BYPASS_EN.
module decode_cycle
  import decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic [PC_W-1:0]    PCPlus4D,
  input  logic               StallD,
  input  logic               FlushE,
  input  logic               RegWriteW,
  input  logic [REG_AW-1:0]  RDW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [REG_AW-1:0]  RdE,
  output logic [REG_AW-1:0]  Rs1E,
  output logic [REG_AW-1:0]  Rs2E,
  output logic [PC_W-1:0]    PCE,
  output logic [PC_W-1:0]    PCPlus4E,
  output logic [3:0]         ALUControlE,
  output logic               ALUSrcE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic [1:0]         ResultSrcE,
  output logic               BranchE,
  output logic               BranchNeE,
  output logic               JumpE,
  output logic               CallE,
  output logic               ReturnE,
  output logic               IllegalE
);

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] link_data;
  ctrl_t             ctrl;
  idex_t             idex_d;
  idex_t             idex_q;

  assign op  = InstrD[OP_LSB  +: OP_W];
  assign rd  = InstrD[RD_LSB  +: REG_AW];
  assign rs1 = InstrD[RS1_LSB +: REG_AW];
  assign rs2 = InstrD[RS2_LSB +: REG_AW];
  assign imm = InstrD[IMM_LSB +: IMM_W];

  register_file u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (RegWriteW),
    .wa    (RDW),
    .wd    (ResultW),
    .ra1   (rs1),
    .ra2   (rs2),
    .ra3   (LINK_REG),
    .rd1_c (rs1_data),
    .rd2_c (rs2_data),
    .rd3_c (link_data)
  );

  // Control decoder; opcodes outside the defined set become an illegal bubble.
  always_comb begin
    ctrl = '0;
    case (opcode_e'(op))
      OP_NOP:  ;
      OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_ADD; end
      OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_SUB; end
      OP_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_AND; end
      OP_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_OR;  end
      OP_XOR:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_XOR; end
      OP_SLL:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_SLL; end
      OP_SRL:  begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_SRL; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_LDR:  begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STR:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BEQ:  begin ctrl.branch    = 1'b1; ctrl.alu = ALU_SUB; end
      OP_BNE:  begin ctrl.branch_ne = 1'b1; ctrl.alu = ALU_SUB; end
      OP_JMP:  ctrl.jump = 1'b1;
      OP_CALL: begin
        ctrl.jump       = 1'b1;
        ctrl.call       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_RET:  ctrl.ret = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // RET sources its target from R15; CALL always links into R15.
  always_comb begin
    idex_d      = '0;
    idex_d.ctrl = ctrl;
    idex_d.rd1  = ctrl.ret ? link_data : rs1_data;
    idex_d.rd2  = rs2_data;
    idex_d.imm  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    idex_d.rd   = ctrl.call ? LINK_REG : rd;
    idex_d.rs1  = ctrl.ret ? LINK_REG : rs1;
    idex_d.rs2  = rs2;
    idex_d.pc   = PCD;
    idex_d.pc4  = PCPlus4D;
  end

  // ID/EX register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else if (!StallD) begin
      idex_q <= idex_d;
    end
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
  assign ALUControlE = idex_q.ctrl.alu;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign BranchE     = idex_q.ctrl.branch;
  assign BranchNeE   = idex_q.ctrl.branch_ne;
  assign JumpE       = idex_q.ctrl.jump;
  assign CallE       = idex_q.ctrl.call;
  assign ReturnE     = idex_q.ctrl.ret;
  assign IllegalE    = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: directed cases followed by random traffic,
// checked against an instruction-level reference model of the ID stage.
module tb_decode_cycle;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [8:0]  pc;
    logic [8:0]  pc4;
    logic [3:0]  alu;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  res_src;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        call;
    logic        ret;
    logic        illegal;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [32:0] InstrD = '0;
  logic [8:0]  PCD = '0;
  logic [8:0]  PCPlus4D = '0;
  logic        StallD = 1'b0;
  logic        FlushE = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [3:0]  RDW = '0;
  logic [31:0] ResultW = '0;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [3:0]  RdE, Rs1E, Rs2E, ALUControlE;
  logic [8:0]  PCE, PCPlus4E;
  logic        ALUSrcE, RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, CallE, ReturnE, IllegalE;
  logic [1:0]  ResultSrcE;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE), .CallE(CallE),
    .ReturnE(ReturnE), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

  logic [31:0] model_rf [16];
  vec_t        sb [$];
  vec_t        last_exp = '0;
  bit          done = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [32:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int imm);
    return {5'(op), 4'(rd), 4'(rs1), 4'(rs2), 16'(imm)};
  endfunction

  function automatic logic [31:0] rf_read(input logic [3:0] a, input logic we,
                                          input logic [3:0] wa, input logic [31:0] wd);
    if (a == 4'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return model_rf[a];
  endfunction

  // Reference: what the execute stage should see for this instruction.
  function automatic vec_t model(input logic [32:0] ins, input logic [8:0] pc,
                                 input logic [8:0] pc4, input logic we,
                                 input logic [3:0] wa, input logic [31:0] wd);
    vec_t v;
    int   op;
    op    = int'(ins[32:28]);
    v     = '0;
    v.rd  = ins[27:24];
    v.rs1 = (op == 15) ? 4'd15 : ins[23:20];
    v.rs2 = ins[19:16];
    v.imm = 32'($signed(ins[15:0]));
    v.pc  = pc;
    v.pc4 = pc4;
    v.rd1 = rf_read(v.rs1, we, wa, wd);
    v.rd2 = rf_read(v.rs2, we, wa, wd);
    if (op >= 1 && op <= 7) begin
      v.reg_write = 1'b1;
      v.alu       = 4'(op - 1);
    end
    case (op)
      8:  begin v.alu_src = 1'b1; v.reg_write = 1'b1; end
      9:  begin v.alu_src = 1'b1; v.reg_write = 1'b1; v.res_src = 2'b01; end
      10: begin v.alu_src = 1'b1; v.mem_write = 1'b1; end
      11: begin v.branch = 1'b1; v.alu = 4'd1; end
      12: begin v.branch_ne = 1'b1; v.alu = 4'd1; end
      13: v.jump = 1'b1;
      14: begin v.jump = 1'b1; v.call = 1'b1; v.reg_write = 1'b1; v.res_src = 2'b10; v.rd = 4'd15; end
      15: v.ret = 1'b1;
      default: if (op >= 16) v.illegal = 1'b1;
    endcase
    return v;
  endfunction

  task automatic step(input logic [32:0] ins, input logic [8:0] pc, input logic stall,
                      input logic flush, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd);
    vec_t e;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 9'd1;
    StallD = stall; FlushE = flush; RegWriteW = we; RDW = wa; ResultW = wd;
    if (flush)      e = '0;
    else if (stall) e = last_exp;
    else            e = model(ins, pc, pc + 9'd1, we, wa, wd);
    last_exp = e;
    sb.push_back(e);
    if (we && wa != 4'd0) model_rf[wa] = wd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Driver
  initial begin
    logic [32:0] ins;
    logic [3:0]  wa;
    for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    step(mk(8, 1, 0, 0, 16'hFFFD), 9'h000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(1, 2, 5, 5, 0), 9'h002, 1'b0, 1'b0, 1'b1, 4'd5, 32'h1234);
    step(mk(1, 2, 5, 5, 0), 9'h003, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(14, 3, 0, 0, 0), 9'h040, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(15, 0, 0, 0, 0), 9'h041, 1'b0, 1'b0, 1'b1, 4'd15, 32'h41);
    step(mk(15, 0, 0, 6, 0), 9'h042, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(10, 0, 5, 2, 16'h0010), 9'h043, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++)
      step(mk(1, 7, 7, 7, 5), 9'(9'h050 + i), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(9, 4, 5, 0, 16'h8000), 9'h060, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    step(mk(20, 4, 5, 5, 16'h1111), 9'h061, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    step(mk(1, 2, 0, 0, 0), 9'h062, 1'b0, 1'b0, 1'b1, 4'd0, 32'hFFFF);
    step(mk(1, 2, 0, 0, 0), 9'h063, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    do_reset();
    step(mk(1, 2, 5, 15, 0), 9'h070, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      if ($urandom_range(0, 9) == 0)
        ins = {5'($urandom_range(16, 31)), 28'($urandom)};
      else
        ins = {5'($urandom_range(0, 15)), 28'($urandom)};
      wa = ($urandom_range(0, 2) == 0) ? ins[23:20] : 4'($urandom);
      step(ins, 9'($urandom), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), wa, $urandom);
    end
    repeat (2) @(negedge clk);
    done = 1'b1;
  end

  // Monitor: ID/EX is checked one cycle after each driven decode, and held at zero in reset.
  initial begin
    vec_t act;
    vec_t exp;
    while (!done) begin
      @(posedge clk or negedge rst);
      #1;
      act = {RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E, ALUControlE,
             ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE,
             JumpE, CallE, ReturnE, IllegalE};
      if (!rst) begin
        vectors++;
        if (act !== '0) begin
          miscompares++;
          $display("FAIL reset t=%0t got=%h exp=0", $time, act);
        end
      end else if (sb.size() > 0) begin
        exp = sb.pop_front();
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL idex t=%0t got=%h exp=%h", $time, act, exp);
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
